// File: rtl/mmio_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl_if
// Brief    : Data-memory port bundle between the store/load path and MMIO.
// Revision : 1.0
// ============================================================================
interface mmio_io_ctrl_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic [DBITS-1:0] rdata;
    logic             hit;

    modport master (output addr, output wdata, output we, input rdata, input hit);
    modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl
// Brief    : HEX/LED output registers, debounced KEY/SW inputs with press
//            events, and a millisecond timer in the FFF0..FFFE window.
// Revision : 1.0
// ============================================================================
module mmio_io_ctrl #(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_CYCLES     = 50000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mmio_io_ctrl_if.slave     bus,
    input  wire logic [3:0]   key,
    input  wire logic [9:0]   sw,
    output logic      [15:0]  hexout,
    output logic      [9:0]   ledrout,
    output logic      [7:0]   ledgout,
    output logic              keyirq
);
    localparam int c_DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    // Bits [3:0] are the active-low keys (idle high), [13:4] the switches.
    localparam logic [13:0] c_IN_RST = {10'b0, 4'hF};

    localparam logic [2:0] c_IDX_KEY  = 3'd0;
    localparam logic [2:0] c_IDX_SW   = 3'd1;
    localparam logic [2:0] c_IDX_EVT  = 3'd2;
    localparam logic [2:0] c_IDX_TMR  = 3'd3;
    localparam logic [2:0] c_IDX_HEX  = 3'd4;
    localparam logic [2:0] c_IDX_LEDR = 3'd5;
    localparam logic [2:0] c_IDX_LEDG = 3'd6;

    logic [13:0]         r_sync1;
    logic [13:0]         r_sync2;
    logic [13:0]         r_stable;
    logic [c_DEB_W-1:0]  r_cnt [14];
    logic [3:0]          r_key_prev;
    logic [3:0]          r_evt;
    logic                r_keyirq;
    logic [c_TICK_W-1:0] r_presc;
    logic [15:0]         r_timer;
    logic [15:0]         r_hex;
    logic [9:0]          r_ledr;
    logic [7:0]          r_ledg;

    logic                w_hit;
    logic                w_wr;
    logic [2:0]          w_idx;
    logic                w_tick;
    logic [3:0]          w_press;
    logic [3:0]          w_clr;
    logic [3:0]          w_evt_next;

    assign w_hit   = (bus.addr[15:4] == 12'hFFF);
    assign w_idx   = bus.addr[3:1];
    assign w_wr    = bus.we && w_hit;
    assign w_tick  = (r_presc == c_TICK_LAST);
    // A press is seen one cycle after the stable key value falls.
    assign w_press = r_key_prev & ~r_stable[3:0];
    assign w_clr   = (w_wr && (w_idx == c_IDX_EVT)) ? bus.wdata[3:0] : 4'b0;
    assign w_evt_next = (r_evt & ~w_clr) | w_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= c_IN_RST;
            r_sync2  <= c_IN_RST;
            r_stable <= c_IN_RST;
            for (int i = 0; i < 14; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= {sw, key};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 14; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_DEB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_DEB_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_prev <= 4'hF;
            r_evt      <= 4'h0;
            r_keyirq   <= 1'b0;
        end else begin
            r_key_prev <= r_stable[3:0];
            r_evt      <= w_evt_next;
            r_keyirq   <= |w_evt_next;
        end
    end

    // The prescaler free-runs; a timer store only overrides the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_timer <= 16'h0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + c_TICK_ONE);
            if (w_wr && (w_idx == c_IDX_TMR)) begin
                r_timer <= bus.wdata[15:0];
            end else if (w_tick) begin
                r_timer <= r_timer + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex  <= 16'h0;
            r_ledr <= 10'h0;
            r_ledg <= 8'h0;
        end else if (w_wr) begin
            if (w_idx == c_IDX_HEX)  r_hex  <= bus.wdata[15:0];
            if (w_idx == c_IDX_LEDR) r_ledr <= bus.wdata[9:0];
            if (w_idx == c_IDX_LEDG) r_ledg <= bus.wdata[7:0];
        end
    end

    always_comb begin
        bus.rdata = DBITS'(16'hDEAD);
        if (w_hit) begin
            case (w_idx)
                c_IDX_KEY:  bus.rdata = DBITS'({12'b0, r_stable[3:0]});
                c_IDX_SW:   bus.rdata = DBITS'({6'b0, r_stable[13:4]});
                c_IDX_EVT:  bus.rdata = DBITS'({12'b0, r_evt});
                c_IDX_TMR:  bus.rdata = DBITS'(r_timer);
                c_IDX_HEX:  bus.rdata = DBITS'(r_hex);
                c_IDX_LEDR: bus.rdata = DBITS'({6'b0, r_ledr});
                c_IDX_LEDG: bus.rdata = DBITS'({8'b0, r_ledg});
                default:    bus.rdata = DBITS'(16'hDEAD);
            endcase
        end
    end

    assign bus.hit = w_hit;
    assign hexout  = r_hex;
    assign ledrout = r_ledr;
    assign ledgout = r_ledg;
    assign keyirq  = r_keyirq;
endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_ctrl
// Brief    : Directed plus randomized bench for mmio_io_ctrl with a
//            cycle-level reference model of the register map.
// Revision : 1.0
// ============================================================================
module tb_mmio_io_ctrl;
    localparam int DEB  = 4;
    localparam int TICK = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [15:0] hexout;
    logic [9:0]  ledrout;
    logic [7:0]  ledgout;
    logic        keyirq;

    mmio_io_ctrl_if #(.DBITS(16)) bus ();

    mmio_io_ctrl #(.DBITS(16), .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .key     (key),
        .sw      (sw),
        .hexout  (hexout),
        .ledrout (ledrout),
        .ledgout (ledgout),
        .keyirq  (keyirq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sampled input pipeline, debounced value, register file.
    logic [13:0] m_s1, m_s2, m_stable;
    int          m_run [14];
    logic [3:0]  m_keyprev, m_evt;
    logic        m_irq;
    logic [15:0] m_timer, m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    int          m_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = {10'b0, 4'hF};
        m_s2 = {10'b0, 4'hF};
        m_stable = {10'b0, 4'hF};
        for (int i = 0; i < 14; i++) m_run[i] = 0;
        m_keyprev = 4'hF; m_evt = 4'h0; m_irq = 1'b0;
        m_timer = 16'h0; m_hex = 16'h0; m_ledr = 10'h0; m_ledg = 8'h0;
        m_cyc = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a[15:4] != 12'hFFF) return 16'hDEAD;
        case (a[3:1])
            3'd0: return {12'b0, m_stable[3:0]};
            3'd1: return {6'b0, m_stable[13:4]};
            3'd2: return {12'b0, m_evt};
            3'd3: return m_timer;
            3'd4: return m_hex;
            3'd5: return {6'b0, m_ledr};
            3'd6: return {8'b0, m_ledg};
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] press, clr;
        logic       wr, tick;
        logic [2:0] idx;
        if (rst) begin
            model_reset();
            return;
        end
        press     = m_keyprev & ~m_stable[3:0];
        m_keyprev = m_stable[3:0];
        // Stable value adopts the sampled input after DEB consecutive disagreeing cycles.
        for (int i = 0; i < 14; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = {sw, key};
        wr   = bus.we && (bus.addr[15:4] == 12'hFFF);
        idx  = bus.addr[3:1];
        clr  = (wr && idx == 3'd2) ? bus.wdata[3:0] : 4'h0;
        m_evt = (m_evt & ~clr) | press;
        m_irq = |m_evt;
        tick  = (m_cyc % TICK) == TICK - 1;
        m_cyc++;
        if (wr && idx == 3'd3) m_timer = bus.wdata;
        else if (tick)         m_timer = m_timer + 16'h1;
        if (wr && idx == 3'd4) m_hex  = bus.wdata;
        if (wr && idx == 3'd5) m_ledr = bus.wdata[9:0];
        if (wr && idx == 3'd6) m_ledg = bus.wdata[7:0];
    endtask

    task automatic compare_all();
        check_eq("rdata",   bus.rdata, m_read(bus.addr));
        check_eq("hit",     bus.hit, bus.addr[15:4] == 12'hFFF);
        check_eq("hexout",  hexout, m_hex);
        check_eq("ledrout", ledrout, m_ledr);
        check_eq("ledgout", ledgout, m_ledg);
        check_eq("keyirq",  keyirq, m_irq);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        cycle();
        bus.we = 1'b0;
    endtask

    logic [15:0] rst_addr [9] = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8,
                                  16'hFFFA, 16'hFFFC, 16'hFFFE, 16'h0200};
    logic [15:0] rst_exp  [9] = '{16'h000F, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                  16'h0000, 16'h0000, 16'hDEAD, 16'hDEAD};

    initial begin
        bool_found_t: begin end
    end

    initial begin
        logic found;
        rst = 1'b1; key = 4'hF; sw = 10'h0;
        bus.we = 1'b0; bus.addr = 16'hFFF0; bus.wdata = 16'h0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            bus.addr = rst_addr[i];
            #1;
            check_eq("reset_read", bus.rdata, rst_exp[i]);
        end
        check_eq("reset_hit_0200", bus.hit, 1'b0);
        check_eq("reset_keyirq", keyirq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        store(16'hFFF8, 16'h1234);
        check_eq("hex_store", hexout, 16'h1234);
        store(16'hFFFA, 16'h03FF);
        check_eq("ledr_store", ledrout, 10'h3FF);
        store(16'hFFFC, 16'hABCD);
        check_eq("ledg_store", ledgout, 8'hCD);
        check_eq("ledg_read", bus.rdata, 16'h00CD);
        store(16'h0400, 16'h5555);
        check_eq("miss_store_hex", hexout, 16'h1234);

        bus.addr = 16'hFFF0;
        key = 4'b1101;
        repeat (3) cycle();
        key = 4'hF;
        repeat (8) cycle();
        check_eq("glitch_key", bus.rdata, 16'h000F);
        check_eq("glitch_irq", keyirq, 1'b0);

        key = 4'b1101;
        repeat (5) cycle();
        check_eq("key_before", bus.rdata, 16'h000F);
        cycle();
        check_eq("key_stable", bus.rdata, 16'h000D);
        bus.addr = 16'hFFF4;
        cycle();
        check_eq("evt_set", bus.rdata, 16'h0002);
        check_eq("evt_irq", keyirq, 1'b1);

        store(16'hFFF4, 16'h0002);
        check_eq("evt_clr", bus.rdata, 16'h0000);
        check_eq("evt_clr_irq", keyirq, 1'b0);

        key = 4'hF;
        repeat (8) cycle();
        key = 4'b1101;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_keyprev[1] && !m_stable[1]) begin
                store(16'hFFF4, 16'h0002);
                found = 1'b1;
            end else begin
                cycle();
            end
        end
        check_eq("press_found", found, 1'b1);
        check_eq("set_beats_clr", bus.rdata, 16'h0002);

        bus.addr = 16'hFFF6;
        repeat (12) cycle();
        store(16'hFFF6, 16'hFFFF);
        repeat (TICK) cycle();
        check_eq("timer_wrap", bus.rdata, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 2 * TICK && !found; i++) begin
            if ((m_cyc % TICK) == TICK - 1) found = 1'b1;
            else cycle();
        end
        check_eq("tick_found", found, 1'b1);
        store(16'hFFF6, 16'h1357);
        check_eq("timer_write_on_tick", bus.rdata, 16'h1357);

        bus.addr = 16'hFFF2;
        sw = 10'h2A5;
        repeat (6) cycle();
        check_eq("sw_stable", bus.rdata, 16'h02A5);
        sw = 10'h2A4;
        cycle();
        sw = 10'h2A5;
        repeat (8) cycle();
        check_eq("sw_glitch", bus.rdata, 16'h02A5);

        for (int n = 0; n < 1500; n++) begin
            int pick;
            bus.we = ($urandom_range(0, 99) < 30);
            pick = int'($urandom_range(0, 9));
            if (pick < 8) bus.addr = 16'hFFF0 + 16'(2 * pick) + 16'($urandom_range(0, 1));
            else          bus.addr = 16'($urandom);
            bus.wdata = 16'($urandom);
            if ($urandom_range(0, 7) == 0) key = 4'($urandom);
            if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
            cycle();
        end
        bus.we = 1'b0;

        bus.addr = 16'hFFF6;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_timer", bus.rdata, 16'h0000);
        check_eq("midrst_hex", hexout, 16'h0000);
        check_eq("midrst_ledr", ledrout, 10'h000);
        check_eq("midrst_ledg", ledgout, 8'h00);
        check_eq("midrst_irq", keyirq, 1'b0);
        bus.addr = 16'hFFF0;
        #1;
        check_eq("midrst_key", bus.rdata, 16'h000F);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
